// File: rtl/shared_divider.sv
// shared_divider: sequential unsigned restoring divider shared by two clients.
// One quotient bit per clock; the result is held until the next accepted request.
module shared_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] dividerres,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned REM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   quo_q, quo_d;   // dividend shift register, becomes quotient
  logic [REM_W-1:0]   rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // latched divisor
  logic [CNT_W-1:0]   cnt_q, cnt_d;   // step counter
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               dz_q, dz_d;

  logic [REM_W-1:0]   trial;
  logic [REM_W-1:0]   diff;
  logic               fits;
  logic [REM_W-1:0]   rem_nxt;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;

  // Next-state, datapath step and output update.
  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    res_d    = res_q;
    rmd_d    = rmd_q;
    dz_d     = dz_q;

    trial        = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff         = trial - {1'b0, dvs_q};
    fits         = (trial >= {1'b0, dvs_q});
    rem_nxt      = fits ? diff : trial;
    sel_dividend = select ? dividend1 : dividend0;
    sel_divisor  = select ? divisor1  : divisor0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CALC;
          quo_d   = sel_dividend;
          dvs_d   = sel_divisor;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          dz_d    = (sel_divisor == '0);
        end
      end
      S_CALC: begin
        quo_d = WIDTH'({quo_q, fits});
        rem_d = rem_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          res_d   = quo_d;
          rmd_d   = rem_nxt[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      res_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      res_q   <= res_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign busy       = busy_q;
  assign ready      = ready_q;
  assign dividerres = res_q;
  assign remainder  = rmd_q;
  assign div_zero   = dz_q;

endmodule

// File: tb/tb_shared_divider.sv
// Directed testbench for shared_divider (WIDTH = 16).
module tb_shared_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         select;
  logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
  logic         busy, ready, div_zero;
  logic [W-1:0] dividerres, remainder;

  int checks   = 0;
  int failures = 0;

  shared_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .select     (select),
    .dividend0  (dividend0),
    .divisor0   (divisor0),
    .dividend1  (dividend1),
    .divisor1   (divisor1),
    .busy       (busy),
    .ready      (ready),
    .dividerres (dividerres),
    .remainder  (remainder),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request: accept, hold busy for W cycles, single ready pulse, then IDLE.
  task automatic run_div(input string tag, input logic sel,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic [W-1:0] prev_q);
    logic held;
    held      = 1'b1;
    select    = sel;
    dividend0 = a0;
    divisor0  = b0;
    dividend1 = a1;
    divisor1  = b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    select    = ~sel;
    dividend0 = ~a0;
    divisor0  = ~b0;
    dividend1 = ~a1;
    divisor1  = ~b1;
    check({tag, "_acc_busy"}, 32'(busy), 32'd1);
    check({tag, "_acc_ready"}, 32'(ready), 32'd0);
    check({tag, "_acc_dz"}, 32'(div_zero), 32'(edz));
    check({tag, "_acc_hold_q"}, 32'(dividerres), 32'(prev_q));
    for (int i = 1; i < int'(W); i++) begin
      tick();
      if (busy !== 1'b1 || ready !== 1'b0) held = 1'b0;
    end
    check({tag, "_busy_16"}, 32'(held), 32'd1);
    tick();
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_ready"}, 32'(ready), 32'd1);
    check({tag, "_quot"}, 32'(dividerres), 32'(eq));
    check({tag, "_rem"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(div_zero), 32'(edz));
    tick();
    check({tag, "_idle_ready"}, 32'(ready), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_quot"}, 32'(dividerres), 32'(eq));
  endtask

  initial begin : stim
    int nbusy;
    int nready;
    int ready_at;
    int n;
    logic [W-1:0] cap_q, cap_r;
    logic         cap_dz;
    logic         b2b_ok;

    rst       = 1'b0;
    start     = 1'b0;
    select    = 1'b0;
    dividend0 = '0;
    divisor0  = '0;
    dividend1 = '0;
    divisor1  = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_quot", 32'(dividerres), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    rst = 1'b1;
    tick();

    // 36000 / 600 from client 0
    run_div("avg", 1'b0, 16'd36000, 16'd600, 16'd1, 16'd1, 16'd60, 16'd0, 1'b0, 16'd0);

    // select = 1 picks client 1 (5/7) over client 0 (1000/3)
    run_div("sel1", 1'b1, 16'd1000, 16'd3, 16'd5, 16'd7, 16'd0, 16'd5, 1'b0, 16'd60);

    // Divide by zero: all-ones quotient, remainder = dividend
    run_div("dz", 1'b0, 16'd1234, 16'd0, 16'd9, 16'd9, 16'hFFFF, 16'd1234, 1'b1, 16'd0);

    // Following request clears div_zero at acceptance
    run_div("clr", 1'b0, 16'd100, 16'd10, 16'd9, 16'd9, 16'd10, 16'd0, 1'b0, 16'hFFFF);

    // start pulsed mid-CALC with other operands (divisor 0) must be ignored
    select    = 1'b0;
    dividend0 = 16'd200;
    divisor0  = 16'd7;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    nbusy     = (busy === 1'b1) ? 1 : 0;
    nready    = 0;
    ready_at  = -1;
    cap_q     = '0;
    cap_r     = '0;
    cap_dz    = 1'b1;
    for (int i = 1; i < 30; i++) begin
      if (i == 5) begin
        select    = 1'b1;
        dividend0 = 16'd9;
        divisor0  = 16'd0;
        dividend1 = 16'd9;
        divisor1  = 16'd0;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      if (busy === 1'b1) nbusy++;
      if (ready === 1'b1) begin
        nready++;
        ready_at = i;
        cap_q    = dividerres;
        cap_r    = remainder;
        cap_dz   = div_zero;
      end
    end
    check("mid_busy_cycles", 32'(nbusy), 32'd16);
    check("mid_ready_count", 32'(nready), 32'd1);
    check("mid_ready_at", 32'(ready_at), 32'd16);
    check("mid_quot", 32'(cap_q), 32'd28);
    check("mid_rem", 32'(cap_r), 32'd4);
    check("mid_dz", 32'(cap_dz), 32'd0);

    // start held high: back-to-back 65535/255, one result every 17 cycles
    select    = 1'b0;
    dividend0 = 16'd65535;
    divisor0  = 16'd255;
    start     = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n      = 0;
      b2b_ok = 1'b1;
      do begin
        tick();
        n++;
        if (k > 0 && n == 1 && (busy !== 1'b1 || ready !== 1'b0)) b2b_ok = 1'b0;
      end while (ready !== 1'b1 && n < 40);
      check($sformatf("b2b%0d_period", k), 32'(n), (k == 0) ? 32'd16 : 32'd17);
      check($sformatf("b2b%0d_handover", k), 32'(b2b_ok), 32'd1);
      check($sformatf("b2b%0d_quot", k), 32'(dividerres), 32'd257);
      check($sformatf("b2b%0d_rem", k), 32'(remainder), 32'd0);
    end
    start = 1'b0;
    tick();
    check("b2b_stop_busy", 32'(busy), 32'd0);

    // Asynchronous reset 5 cycles into CALC aborts without a ready pulse
    dividend0 = 16'd500;
    divisor0  = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("ar_acc_dz", 32'(div_zero), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_ready", 32'(ready), 32'd0);
    check("ar_quot", 32'(dividerres), 32'd0);
    check("ar_rem", 32'(remainder), 32'd0);
    check("ar_dz", 32'(div_zero), 32'd0);
    tick();
    tick();
    rst    = 1'b1;
    nready = 0;
    nbusy  = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ready === 1'b1) nready++;
      if (busy === 1'b1) nbusy++;
    end
    check("ar_no_ready", 32'(nready), 32'd0);
    check("ar_no_busy", 32'(nbusy), 32'd0);

    // Normal request after the abort
    run_div("post", 1'b0, 16'd40000, 16'd7, 16'd1, 16'd1, 16'd5714, 16'd2, 1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_divider.md
# shared_divider

Sequential unsigned restoring divider that answers division requests from the bike computer's statistic blocks, such as average speed. It is the responder end of the dividend/divisor/busy/ready/result handshake. A top-level `select` chooses which of two client operand pairs is latched on `start`. One quotient bit is produced per clock. The divider owns `busy` and `ready`, and holds the result until the next accepted request.

## Interface
- `WIDTH`, default 16: width of dividend, divisor, quotient and remainder.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe from top-level controller; sampled every edge.
- `select`  in  1  client select at acceptance: 0 = client 0, 1 = client 1.
- `dividend0`, `divisor0`  in  WIDTH each  client 0 operands.
- `dividend1`, `divisor1`  in  WIDTH each  client 1 operands.
- `busy`  out  1  high while a division is in progress.
- `ready`  out  1  one-cycle pulse when the result is valid.
- `dividerres`  out  WIDTH  quotient.
- `remainder`  out  WIDTH  remainder.
- `div_zero`  out  1  latched flag: the last accepted request had divisor 0.

## Operation
- States are IDLE, CALC and DONE. Internal registers:
  - dividend shift register `q`, WIDTH bits;
  - partial remainder `r`, WIDTH+1 bits;
  - latched divisor `d`, WIDTH bits;
  - step counter, clog2(WIDTH) bits.
- Acceptance:
  - `start`=1 is accepted when the state is IDLE or DONE.
  - On the accepting edge, operands are latched from the client chosen by `select`: `q`←dividend, `d`←divisor, `r`←0, counter←0.
  - Also on that edge: `div_zero`←(divisor==0), `busy`←1, state←CALC.
- `start` in CALC is ignored. It is neither queued nor allowed to alter operands or `select`.
- CALC, one step per edge:
  - t = {r[WIDTH-1:0], q[WIDTH-1]};
  - if t ≥ {1'b0,d}: r←t−d and shift 1 into `q` LSB; otherwise r←t and shift 0 into `q`.
  - Counter increments each step.
  - On the step where counter==WIDTH−1: state←DONE, `busy`←0, `ready`←1, `dividerres`←final quotient, `remainder`←final r[WIDTH-1:0].
- DONE lasts exactly one cycle. Without `start`, it returns to IDLE and `ready`←0.
- Divide by zero takes no special path. The algorithm itself yields quotient all ones (2^WIDTH−1) and remainder = dividend. `div_zero` is set for that result.
- `dividerres`, `remainder` and `div_zero`:
  - hold their values from DONE through IDLE;
  - remain unchanged during a subsequent CALC until its DONE;
  - exception: `div_zero` updates at acceptance.
- Arithmetic is unsigned only. Clients are responsible for saturating or truncating the quotient.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `busy`=0, `ready`=0, `dividerres`=0, `remainder`=0, `div_zero`=0, internal registers 0.
- Release of reset is synchronous to `clk`. A mid-calculation reset aborts the operation with no `ready` pulse.
- Latency, with `start` sampled at edge E0:
  - `busy`=1 after E0, for exactly WIDTH cycles;
  - at edge E0+WIDTH, `busy`→0 and `ready`→1 simultaneously;
  - `ready` drops at E0+WIDTH+1 unless a new result is being produced.
- Back-to-back: `start` high during the DONE cycle is accepted at E0+WIDTH+1. `busy` rises and `ready` falls on that same edge. Throughput is one result per WIDTH+1 cycles.
- Client protocol:
  - wait for `busy`=0 and present operands;
  - controller pulses `start`;
  - client sees `busy`=1, then `ready`=1;
  - client captures `dividerres` in the `ready` cycle or any later cycle before its next request.
- Operands only need to be stable on the accepting edge.

## Test plan
- Reset, then client 0 with 36000/600, `select`=0, one `start` pulse:
  - `busy` high exactly 16 cycles;
  - `ready` pulse on the 16th edge after acceptance;
  - `dividerres`=60, `remainder`=0, `div_zero`=0.
- Client 1 with 5/7 and client 0 with 1000/3, `select`=1:
  - `dividerres`=0, `remainder`=5, proving client 1 was latched.
- Divisor 0 with dividend 1234:
  - after 16 cycles, `dividerres`=0xFFFF, `remainder`=1234, `div_zero`=1.
  - A following request 100/10 gives 10 and clears `div_zero` at acceptance.
- `start` pulsed again mid-CALC with different operands:
  - ignored; no change to `busy` duration or result;
  - exactly one `ready` pulse.
- `start` held high continuously with 65535/255:
  - `ready` every 17 cycles, each `dividerres`=257, `remainder`=0;
  - `busy` rises on the same edge `ready` falls.
- `rst` driven low asynchronously 5 cycles into CALC:
  - all outputs 0 immediately;
  - no `ready` pulse afterwards;
  - the next request completes normally.
